// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: picks the next PC from sequential/branch/jump/exception
// sources, paces updates with the imem handshake and hazard stall, and holds late redirects.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc_cur,
    output logic [31:0] o_pc_next,
    output logic        o_pc_en_n,
    output logic        o_imem_req,
    input  logic        i_imem_ack,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_exc,
    output logic [31:0] o_epc,
    output logic        o_ifid_write,
    output logic        o_ifid_flush
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [1:0] PRIO_NONE   = 2'd0;
    localparam logic [1:0] PRIO_JUMP   = 2'd1;
    localparam logic [1:0] PRIO_BRANCH = 2'd2;
    localparam logic [1:0] PRIO_EXC    = 2'd3;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_pend_v;
    logic [31:0] r_pend_addr;
    logic [1:0]  r_pend_prio;
    logic [31:0] r_epc;

    logic        w_pend_v_next;
    logic [31:0] w_pend_addr_next;
    logic [1:0]  w_pend_prio_next;
    logic [31:0] w_epc_next;

    logic [31:0] w_seq_addr;
    logic        w_cur_v;
    logic [31:0] w_cur_addr;
    logic [1:0]  w_cur_prio;
    logic        w_running;
    logic        w_ready;
    logic        w_take_pend;
    logic        w_take_cur;
    logic        w_pend_live;
    logic        w_latch;
    logic        w_overwrite;
    logic        w_pend_exc;
    logic [31:0] w_redirect_addr;

    assign w_seq_addr = i_pc_cur + 32'd4;

    always_comb begin
        w_cur_v    = 1'b1;
        w_cur_addr = EXC_VECTOR;
        w_cur_prio = PRIO_EXC;
        if (i_exc) begin
            w_cur_addr = EXC_VECTOR;
            w_cur_prio = PRIO_EXC;
        end else if (i_branch_taken) begin
            w_cur_addr = i_branch_target;
            w_cur_prio = PRIO_BRANCH;
        end else if (i_jump) begin
            w_cur_addr = i_jump_target;
            w_cur_prio = PRIO_JUMP;
        end else begin
            w_cur_v    = 1'b0;
            w_cur_addr = w_seq_addr;
            w_cur_prio = PRIO_NONE;
        end
    end

    // A held redirect always goes first; a redirect arriving in that same cycle
    // cannot be applied and takes the freed pending slot instead.
    assign w_running       = (r_state != ST_BOOT);
    assign w_ready         = ((r_state == ST_FETCH) && i_imem_ack && !i_stall) ||
                             ((r_state == ST_STALL) && !i_stall);
    assign w_take_pend     = w_ready && r_pend_v;
    assign w_take_cur      = w_ready && !r_pend_v && w_cur_v;
    assign w_pend_live     = r_pend_v && !w_take_pend;
    assign w_latch         = w_running && w_cur_v && !w_take_cur;
    assign w_overwrite     = w_latch && (!w_pend_live || (w_cur_prio >= r_pend_prio));
    assign w_pend_exc      = w_pend_live && (r_pend_prio == PRIO_EXC);
    assign w_redirect_addr = r_pend_v ? r_pend_addr : w_cur_addr;

    always_comb begin
        w_pend_v_next    = w_pend_live || w_latch;
        w_pend_addr_next = r_pend_addr;
        w_pend_prio_next = r_pend_prio;
        w_epc_next       = r_epc;
        if (w_overwrite) begin
            w_pend_addr_next = w_cur_addr;
            w_pend_prio_next = w_cur_prio;
        end
        // The first exception's PC is kept until that exception has been applied.
        if (w_running && i_exc && !w_pend_exc) begin
            w_epc_next = i_pc_cur;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_pc_next    = w_seq_addr;
        o_pc_en_n    = 1'b1;
        o_imem_req   = 1'b0;
        o_ifid_write = 1'b0;
        o_ifid_flush = 1'b0;
        case (r_state)
            ST_BOOT: begin
                o_pc_next    = RESET_VECTOR;
                o_pc_en_n    = 1'b0;
                o_ifid_flush = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                o_imem_req = 1'b1;
                if (i_stall) begin
                    w_state_next = ST_STALL;
                end else if (i_imem_ack) begin
                    o_pc_en_n = 1'b0;
                    if (w_take_pend || w_take_cur) begin
                        o_pc_next    = w_redirect_addr;
                        o_ifid_flush = 1'b1;
                    end else begin
                        o_ifid_write = 1'b1;
                    end
                end
            end
            ST_STALL: begin
                if (!i_stall) begin
                    w_state_next = ST_FETCH;
                    if (w_take_pend || w_take_cur) begin
                        o_pc_next    = w_redirect_addr;
                        o_pc_en_n    = 1'b0;
                        o_ifid_flush = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
        if (!i_reset) begin
            w_state_next = ST_BOOT;
            o_pc_next    = RESET_VECTOR;
            o_pc_en_n    = 1'b1;
            o_imem_req   = 1'b0;
            o_ifid_write = 1'b0;
            o_ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= ST_BOOT;
            r_pend_v    <= 1'b0;
            r_pend_addr <= 32'd0;
            r_pend_prio <= PRIO_NONE;
            r_epc       <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_pend_v    <= w_pend_v_next;
            r_pend_addr <= w_pend_addr_next;
            r_pend_prio <= w_pend_prio_next;
            r_epc       <= w_epc_next;
        end
    end

    assign o_epc = r_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, scored against a
// queue-based behavioural model that also plays the role of the PC register.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_cur = 32'd0;
    logic [31:0] pc_next;
    logic        pc_en_n;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        exc = 1'b0;
    logic [31:0] epc;
    logic        ifid_write;
    logic        ifid_flush;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_pc_cur        (pc_cur),
        .o_pc_next       (pc_next),
        .o_pc_en_n       (pc_en_n),
        .o_imem_req      (imem_req),
        .i_imem_ack      (imem_ack),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_exc           (exc),
        .o_epc           (epc),
        .o_ifid_write    (ifid_write),
        .o_ifid_flush    (ifid_flush)
    );

    typedef struct {
        logic [31:0] addr;
        int          prio;
    } redir_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_next;
        bit          chk_next;
        bit          req;
        bit          en_n;
        bit          wr;
        bit          fl;
        logic [31:0] epc;
    } exp_t;

    exp_t   exp_q[$];
    int     n_vec = 0;
    int     n_mis = 0;

    // Model state: current values and the values they take at the next edge.
    logic [31:0] m_pc = 32'hDEAD_BEE0, n_pc = 32'hDEAD_BEE0;
    logic [31:0] m_epc = 32'd0, n_epc = 32'd0;
    bit          m_boot = 1'b1, n_boot = 1'b1;
    bit          m_frozen = 1'b0, n_frozen = 1'b0;
    redir_t      m_pend[$];
    redir_t      n_pend[$];

    task automatic cyc(input bit rst, input bit ack, input bit stl, input bit ex,
                       input bit br, input logic [31:0] bt,
                       input bit jp, input logic [31:0] jt);
        exp_t   e;
        redir_t cur;
        redir_t tmp;
        bit     cur_v;
        bit     ready;
        bit     took_cur;
        bit     pend_live;
        @(posedge clk);
        m_pc = n_pc;  m_epc = n_epc;  m_boot = n_boot;  m_frozen = n_frozen;
        m_pend = n_pend;
        #1;
        reset = rst;  imem_ack = ack;  stall = stl;  exc = ex;
        branch_taken = br;  branch_target = bt;  jump = jp;  jump_target = jt;
        pc_cur = m_pc;

        e.pc = m_pc;  e.pc_next = 32'd0;  e.chk_next = 1'b0;  e.req = 1'b0;
        e.en_n = 1'b1;  e.wr = 1'b0;  e.fl = 1'b0;  e.epc = m_epc;
        n_pend = m_pend;  n_boot = m_boot;  n_frozen = m_frozen;  n_epc = m_epc;
        took_cur = 1'b0;

        cur_v = 1'b1;
        if (ex)      cur = '{EXC_VECTOR, 3};
        else if (br) cur = '{bt, 2};
        else if (jp) cur = '{jt, 1};
        else begin   cur = '{32'd0, 0}; cur_v = 1'b0; end

        if (!rst) begin
            e.pc_next = RESET_VECTOR;  e.chk_next = 1'b1;  e.fl = 1'b1;
            n_boot = 1'b1;  n_frozen = 1'b0;  n_epc = 32'd0;  n_pend.delete();
        end else if (m_boot) begin
            e.pc_next = RESET_VECTOR;  e.chk_next = 1'b1;  e.en_n = 1'b0;  e.fl = 1'b1;
            n_boot = 1'b0;
        end else begin
            e.req = !m_frozen;
            ready = !stl && (m_frozen || ack);
            if (ready) begin
                n_frozen = 1'b0;
                if (n_pend.size() > 0) begin
                    tmp = n_pend.pop_front();
                    e.pc_next = tmp.addr;  e.en_n = 1'b0;  e.fl = 1'b1;  e.chk_next = 1'b1;
                end else if (cur_v) begin
                    e.pc_next = cur.addr;  e.en_n = 1'b0;  e.fl = 1'b1;  e.chk_next = 1'b1;
                    took_cur = 1'b1;
                end else if (!m_frozen) begin
                    e.pc_next = m_pc + 32'd4;  e.en_n = 1'b0;  e.wr = 1'b1;  e.chk_next = 1'b1;
                end
            end else begin
                n_frozen = m_frozen || stl;
            end
            pend_live = (n_pend.size() > 0);
            if (ex && !(pend_live && n_pend[0].prio == 3)) n_epc = m_pc;
            if (cur_v && !took_cur) begin
                if (!pend_live) n_pend.push_back(cur);
                else if (cur.prio >= n_pend[0].prio) n_pend[0] = cur;
            end
        end
        n_pc = e.en_n ? m_pc : e.pc_next;
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit ack);
        cyc(1'b1, ack, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(1'b1);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s vec=%0d actual=%08h required=%08h", name, n_vec, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                $display("vec %0d pc=%08h next=%08h en_n=%0b req=%0b wr=%0b fl=%0b epc=%08h",
                         n_vec, e.pc, pc_next, pc_en_n, imem_req, ifid_write, ifid_flush, epc);
                cmp("imem_req", {31'd0, imem_req}, {31'd0, e.req});
                cmp("pc_en_n", {31'd0, pc_en_n}, {31'd0, e.en_n});
                cmp("ifid_write", {31'd0, ifid_write}, {31'd0, e.wr});
                cmp("ifid_flush", {31'd0, ifid_flush}, {31'd0, e.fl});
                cmp("epc", epc, e.epc);
                if (e.chk_next) cmp("pc_next", pc_next, e.pc_next);
            end
        end
    end

    initial begin : stimulus
        bit          r_rst, r_ack, r_stl, r_ex, r_br, r_jp;
        logic [31:0] r_bt, r_jt;
        // Reset then zero-wait fetch, then three wait states at PC=8.
        do_reset(2);
        idle(1'b1); idle(1'b1);
        repeat (3) idle(1'b0);
        idle(1'b1); idle(1'b1);
        // Branch to 0x40 pulsed during a wait state at PC=8.
        do_reset(1);
        idle(1'b1); idle(1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
        idle(1'b0);
        idle(1'b1); idle(1'b1);
        // Exception and branch together at PC=0x20.
        do_reset(1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h20);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 32'd0);
        idle(1'b1); idle(1'b1);
        // Stall at PC=0x10 with a jump to 0x100 during the stall.
        do_reset(1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h100);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(1'b1); idle(1'b1); idle(1'b1);
        // Reset while stalled with a redirect pending.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h500);
        idle(1'b1); idle(1'b1); idle(1'b1);
        // Sequential wrap from the top of the address space.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        idle(1'b1); idle(1'b1);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r_rst = ($urandom_range(0, 63) != 0);
            r_ack = ($urandom_range(0, 3) != 0);
            r_stl = ($urandom_range(0, 4) == 0);
            r_ex  = ($urandom_range(0, 15) == 0);
            r_br  = ($urandom_range(0, 7) == 0);
            r_jp  = ($urandom_range(0, 7) == 0);
            r_bt  = $urandom() & 32'hFFFF_FFFC;
            r_jt  = $urandom() & 32'hFFFF_FFFC;
            cyc(r_rst, r_ack, r_stl, r_ex, r_br, r_bt, r_jp, r_jt);
        end
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
